// File: rtl/mouse_position_tracker.sv
// -----------------------------------------------------------------------------
// mouse_position_tracker
//
// Assembles 3-byte PS/2 mouse packets (header, dx, dy) and integrates the
// relative motion into an absolute, screen-clamped cursor position.
//
// Parameters
//   X_MAX, Y_MAX     rightmost column / bottom row in pixels
//   X_INIT, Y_INIT   cursor position after reset
//   TIMEOUT_CYCLES   max clk cycles allowed between bytes of one packet
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   byte_valid  one-cycle strobe qualifying byte_data
//   byte_data   received PS/2 byte
//   x_mouse     cursor X, unsigned Q20.12 (fraction always zero)
//   y_mouse     cursor Y, unsigned Q20.12, grows downward
//   buttons     {middle, right, left} from the last accepted packet
//   pos_valid   one-cycle pulse when position/buttons were just updated
//   sync_error  one-cycle pulse on a discarded byte or a timed-out packet
// -----------------------------------------------------------------------------
module mouse_position_tracker #(
    parameter int X_MAX          = 639,
    parameter int Y_MAX          = 479,
    parameter int X_INIT         = 320,
    parameter int Y_INIT         = 240,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] x_mouse,
    output logic [31:0] y_mouse,
    output logic [2:0]  buttons,
    output logic        pos_valid,
    output logic        sync_error
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic signed [21:0] X_MAX_S = 22'(X_MAX);
    localparam logic signed [21:0] Y_MAX_S = 22'(Y_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GOT0 = 2'd1,
        GOT1 = 2'd2
    } state_t;

    state_t            state_r, state_s, eff_state_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    // Header with the always-one sync bit dropped:
    // [6] Y ovf, [5] X ovf, [4] Y sign, [3] X sign, [2:0] {middle, right, left}
    logic [6:0]        hdr_r, hdr_s;
    logic [7:0]        dx_r, dx_s;
    logic [7:0]        dy_r, dy_s;
    logic              upd_r, upd_s;
    logic              sync_err_s;
    logic              timeout_s;

    logic [19:0]       x_pix_r, y_pix_r;
    logic [2:0]        buttons_r;
    logic              pos_valid_r, sync_error_r;

    logic signed [21:0] dx_ext_s, dy_ext_s;
    logic signed [21:0] x_sum_s, y_sum_s;
    logic [19:0]        x_new_s, y_new_s;

    // Packet assembly: next state, byte latches, inter-byte timeout counter.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        hdr_s      = hdr_r;
        dx_s       = dx_r;
        dy_s       = dy_r;
        upd_s      = 1'b0;
        sync_err_s = 1'b0;
        timeout_s  = (state_r != IDLE) && (cnt_r == CNT_W'(TIMEOUT_CYCLES));

        // A timeout drops the partial packet and lets a coincident byte be
        // judged as a fresh byte0 in the very same cycle.
        if (timeout_s) begin
            eff_state_s = IDLE;
            sync_err_s  = 1'b1;
        end else begin
            eff_state_s = state_r;
        end

        case (eff_state_s)
            IDLE: begin
                state_s = IDLE;
                cnt_s   = {CNT_W{1'b0}};
                if (byte_valid) begin
                    if (byte_data[3]) begin
                        hdr_s   = {byte_data[7:4], byte_data[2:0]};
                        state_s = GOT0;
                    end else begin
                        sync_err_s = 1'b1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            GOT0: begin
                if (byte_valid) begin
                    dx_s    = byte_data;
                    cnt_s   = {CNT_W{1'b0}};
                    state_s = GOT1;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            GOT1: begin
                if (byte_valid) begin
                    dy_s    = byte_data;
                    cnt_s   = {CNT_W{1'b0}};
                    state_s = IDLE;
                    upd_s   = 1'b1;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Packet assembly state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            hdr_r   <= 7'd0;
            dx_r    <= 8'd0;
            dy_r    <= 8'd0;
            upd_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            hdr_r   <= hdr_s;
            dx_r    <= dx_s;
            dy_r    <= dy_s;
            upd_r   <= upd_s;
        end
    end

    // Signed motion and clamped new position; wide enough that no sum wraps.
    always_comb begin
        if (hdr_r[5]) begin
            dx_ext_s = 22'sd0;
        end else begin
            dx_ext_s = {{13{hdr_r[3]}}, hdr_r[3], dx_r};
        end
        if (hdr_r[6]) begin
            dy_ext_s = 22'sd0;
        end else begin
            dy_ext_s = {{13{hdr_r[4]}}, hdr_r[4], dy_r};
        end

        // PS/2 Y is up-positive, screen Y is down-positive.
        x_sum_s = $signed({2'b00, x_pix_r}) + dx_ext_s;
        y_sum_s = $signed({2'b00, y_pix_r}) - dy_ext_s;

        if (x_sum_s < 22'sd0) begin
            x_new_s = 20'd0;
        end else if (x_sum_s > X_MAX_S) begin
            x_new_s = X_MAX_S[19:0];
        end else begin
            x_new_s = x_sum_s[19:0];
        end

        if (y_sum_s < 22'sd0) begin
            y_new_s = 20'd0;
        end else if (y_sum_s > Y_MAX_S) begin
            y_new_s = Y_MAX_S[19:0];
        end else begin
            y_new_s = y_sum_s[19:0];
        end
    end

    // Output registers: position/buttons update one cycle after byte2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_pix_r      <= 20'(X_INIT);
            y_pix_r      <= 20'(Y_INIT);
            buttons_r    <= 3'd0;
            pos_valid_r  <= 1'b0;
            sync_error_r <= 1'b0;
        end else begin
            pos_valid_r  <= upd_r;
            sync_error_r <= sync_err_s;
            if (upd_r) begin
                x_pix_r   <= x_new_s;
                y_pix_r   <= y_new_s;
                buttons_r <= hdr_r[2:0];
            end else begin
                x_pix_r   <= x_pix_r;
                y_pix_r   <= y_pix_r;
                buttons_r <= buttons_r;
            end
        end
    end

    assign x_mouse    = {x_pix_r, 12'h000};
    assign y_mouse    = {y_pix_r, 12'h000};
    assign buttons    = buttons_r;
    assign pos_valid  = pos_valid_r;
    assign sync_error = sync_error_r;

endmodule

// File: tb/tb_mouse_position_tracker.sv
module tb_mouse_position_tracker;

    localparam int T_OUT = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic [31:0] x_mouse;
    logic [31:0] y_mouse;
    logic [2:0]  buttons;
    logic        pos_valid;
    logic        sync_error;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference cursor state in plain integers
    int         mx;
    int         my;
    logic [2:0] mb;

    mouse_position_tracker #(
        .X_MAX(639), .Y_MAX(479), .X_INIT(320), .Y_INIT(240),
        .TIMEOUT_CYCLES(T_OUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .byte_valid(byte_valid), .byte_data(byte_data),
        .x_mouse(x_mouse), .y_mouse(y_mouse), .buttons(buttons),
        .pos_valid(pos_valid), .sync_error(sync_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int clamp(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    // Apply one packet to the reference cursor
    function automatic void model_packet(input logic [7:0] h, input logic [7:0] b1, input logic [7:0] b2);
        int dx;
        int dy;
        dx = h[4] ? int'(b1) - 256 : int'(b1);
        dy = h[5] ? int'(b2) - 256 : int'(b2);
        if (h[6]) dx = 0;
        if (h[7]) dy = 0;
        mx = clamp(mx + dx, 639);
        my = clamp(my - dy, 479);
        mb = h[2:0];
    endfunction

    // Called at a negedge; returns at the negedge after the accept edge
    task automatic send_byte(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_data  = b;
        @(negedge clk);
        byte_valid = 1'b0;
        byte_data  = 8'h00;
    endtask

    task automatic check_pos(input string tag);
        check({tag, "_pv"}, 32'(pos_valid), 32'd1);
        check({tag, "_x"}, x_mouse, 32'(mx) << 12);
        check({tag, "_y"}, y_mouse, 32'(my) << 12);
        check({tag, "_btn"}, 32'(buttons), 32'(mb));
    endtask

    task automatic send_pkt(input logic [7:0] h, input logic [7:0] b1, input logic [7:0] b2, input int gap);
        send_byte(h);
        repeat (gap) @(negedge clk);
        send_byte(b1);
        repeat (gap) @(negedge clk);
        send_byte(b2);
        check("pv_early", 32'(pos_valid), 32'd0);
        model_packet(h, b1, b2);
        @(negedge clk);
        check_pos("pkt");
        @(negedge clk);
        check("pv_once", 32'(pos_valid), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_x"}, x_mouse, 32'h0014_0000);
        check({tag, "_y"}, y_mouse, 32'h000F_0000);
        check({tag, "_btn"}, 32'(buttons), 32'd0);
        check({tag, "_pv"}, 32'(pos_valid), 32'd0);
        check({tag, "_se"}, 32'(sync_error), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        @(negedge clk);
        mx = 320;
        my = 240;
        mb = 3'd0;
    endtask

    initial begin
        int early;
        int total;
        logic [31:0] xs;
        logic [7:0]  h;

        rst_n      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        mx = 320; my = 240; mb = 3'd0;
        @(negedge clk);

        // Basic packet
        do_reset();
        send_pkt(8'h09, 8'h05, 8'h03, 0);
        check("basic_x_lit", x_mouse, 32'h0014_5000);
        check("basic_y_lit", y_mouse, 32'h000E_D000);

        // Negative dx
        do_reset();
        send_pkt(8'h18, 8'hFB, 8'h00, 1);
        check("neg_x_lit", x_mouse, 32'h0013_B000);
        check("neg_y_lit", y_mouse, 32'h000F_0000);

        // Clamp at left edge and bottom edge
        do_reset();
        send_pkt(8'h18, 8'h80, 8'h00, 0);
        send_pkt(8'h18, 8'h80, 8'h00, 0);
        send_pkt(8'h18, 8'hC2, 8'h00, 0);
        check("x_at2", x_mouse, 32'h0000_2000);
        send_pkt(8'h18, 8'hF6, 8'h00, 0);
        check("x_clamp0", x_mouse, 32'h0000_0000);
        for (int i = 0; i < 30; i++) send_pkt(8'h28, 8'h00, 8'hF6, 0);
        check("y_clampmax", y_mouse, 32'h001D_F000);

        // X overflow ignores dx
        xs = x_mouse;
        send_pkt(8'h48, 8'h7F, 8'h02, 0);
        check("ovf_x_hold", x_mouse, xs);
        check("ovf_y_lit", y_mouse, 32'h001D_D000);

        // Discarded byte in IDLE
        send_byte(8'h00);
        check("junk_se", 32'(sync_error), 32'd1);
        check("junk_pv", 32'(pos_valid), 32'd0);
        @(negedge clk);
        check("junk_se_off", 32'(sync_error), 32'd0);

        // Timeout after a lone header, then a fresh packet
        send_byte(8'h08);
        early = 0;
        total = 0;
        for (int i = 1; i <= 3 * T_OUT; i++) begin
            @(negedge clk);
            if (sync_error) begin
                total++;
                if (i < T_OUT) early++;
            end
        end
        check("tmo_early", 32'(early), 32'd0);
        check("tmo_count", 32'(total), 32'd1);
        send_pkt(8'h08, 8'h01, 8'h01, 0);

        // Byte0 arriving in the update cycle; zero-motion packet still pulses
        send_byte(8'h09);
        send_byte(8'h05);
        send_byte(8'h03);
        model_packet(8'h09, 8'h05, 8'h03);
        send_byte(8'h0C);
        check_pos("b2b");
        send_byte(8'h00);
        send_byte(8'h00);
        model_packet(8'h0C, 8'h00, 8'h00);
        @(negedge clk);
        check_pos("zero_mv");
        @(negedge clk);

        // Reset mid-packet
        send_byte(8'h08);
        send_byte(8'h05);
        do_reset();
        send_pkt(8'h09, 8'h05, 8'h03, 0);
        check("midrst_x_lit", x_mouse, 32'h0014_5000);

        // Randomized packets with occasional junk bytes
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                h = 8'($urandom) & 8'hF7;
                send_byte(h);
                check("rnd_junk_se", 32'(sync_error), 32'd1);
                @(negedge clk);
            end
            h = 8'($urandom) | 8'h08;
            send_pkt(h, 8'($urandom), 8'($urandom), $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
